jtframe_joyser: RTL



---
 rtl/jtframe_joyser_pkg.sv | 21 ++
 rtl/jtframe_joyser_div.sv | 29 ++
 rtl/jtframe_joyser.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/jtframe_joyser_pkg.sv
// Shared state encoding and width helpers for the jtframe_joyser serial pad reader.
package jtframe_joyser_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        LATCH    = 3'd4
    } joyser_state_e;

    function automatic int joyser_total(input int players, input int bits);
        return players * bits;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int joyser_cntw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/jtframe_joyser_div.sv
// Phase timer: counts CLKDIV clk_sys cycles per joy_clk half-period and flags the last one.
module jtframe_joyser_div #(
    parameter int CLKDIV = 16
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic restart_i,
    output logic tick_o
);
    import jtframe_joyser_pkg::*;

    localparam int W = joyser_cntw(CLKDIV);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == W'(CLKDIV - 1));

    // Wrapping on the tick lets back-to-back phases run without a restart.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || tick_o) cnt_d = '0;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/jtframe_joyser.sv
// Parametrised shift-register joystick reader with frame strobe and sticky OSD combo.
// Optional build macro JTFRAME_JOYSER_DEBOUNCE_EN: a bit changes only after two agreeing frames.
module jtframe_joyser #(
    parameter int              PLAYERS    = 2,
    parameter int              BITS       = 16,
    parameter int              CLKDIV     = 16,
    parameter int              POLL       = 1024,
    parameter int              ACTIVE_LOW = 1,
    parameter logic [BITS-1:0] COMBO_MASK = BITS'(16'h0C00)
) (
    input  logic                    clk_sys,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    combo_clr,
    output logic                    joy_clk,
    output logic                    joy_load,
    input  logic                    joy_data,
    output logic [PLAYERS*BITS-1:0] joystick,
    output logic                    valid,
    output logic                    combo
);
    import jtframe_joyser_pkg::*;

    localparam int TOTAL = joyser_total(PLAYERS, BITS);
    localparam int BCW   = $clog2(TOTAL + 1);
    localparam int PW    = joyser_cntw(POLL);

    joyser_state_e    state_q, state_d;
    logic [BCW-1:0]   bitcnt_q, bitcnt_d;
    logic [PW-1:0]    poll_q, poll_d;
    logic             fresh_q, fresh_d;
    logic [TOTAL-1:0] shadow_q, shadow_d;
    logic [TOTAL-1:0] joy_q, joy_d, frame_d;
    logic             combo_q, combo_d;
    logic             joy_clk_q, joy_load_q, valid_q;
    logic             sync1_q, sync2_q;
    logic             tick, latch, sample, set_combo;

    jtframe_joyser_div #(.CLKDIV(CLKDIV)) u_div (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .restart_i ((state_q == IDLE) || (state_q == LATCH)),
        .tick_o    (tick)
    );

    assign sample = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        poll_d   = poll_q;
        fresh_d  = fresh_q;
        shadow_d = shadow_q;
        latch    = 1'b0;
        case (state_q)
            IDLE: begin
                // fresh_q stands in for "counter just reset" so the first frame needs no wait.
                if (enable && (fresh_q || poll_q == PW'(POLL - 1))) begin
                    state_d = LOAD;
                    fresh_d = 1'b0;
                end else if (poll_q != PW'(POLL - 1)) begin
                    poll_d = poll_q + 1'b1;
                end
            end
            LOAD: if (tick) begin
                state_d  = SHIFT_LO;
                bitcnt_d = '0;
            end
            SHIFT_LO: if (tick) begin
                for (int i = 0; i < TOTAL; i++)
                    if (bitcnt_q == BCW'(i)) shadow_d[i] = sample;
                if (bitcnt_q == BCW'(TOTAL - 1)) begin
                    state_d = LATCH;
                    latch   = 1'b1;
                end else begin
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: if (tick) begin
                bitcnt_d = bitcnt_q + 1'b1;
                state_d  = SHIFT_LO;
            end
            LATCH: begin
                poll_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef JTFRAME_JOYSER_DEBOUNCE_EN
    logic [TOTAL-1:0] prev_q, agree;
    assign agree   = ~(shadow_d ^ prev_q);
    assign frame_d = (agree & shadow_d) | (~agree & joy_q);

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n)     prev_q <= '0;
        else if (latch) prev_q <= shadow_d;
    end
`else
    assign frame_d = shadow_d;
`endif

    // The final bit is folded in via shadow_d so joystick and valid appear together in LATCH.
    assign set_combo = latch && ((frame_d[BITS-1:0] & COMBO_MASK) == COMBO_MASK);
    assign joy_d     = latch ? frame_d : joy_q;
    assign combo_d   = set_combo | (combo_q & ~combo_clr);

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bitcnt_q   <= '0;
            poll_q     <= '0;
            fresh_q    <= 1'b1;
            joy_q      <= '0;
            combo_q    <= 1'b0;
            joy_clk_q  <= 1'b0;
            joy_load_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            poll_q     <= poll_d;
            fresh_q    <= fresh_d;
            joy_q      <= joy_d;
            combo_q    <= combo_d;
            joy_clk_q  <= (state_d == SHIFT_HI);
            joy_load_q <= (state_d == LOAD);
            valid_q    <= (state_d == LATCH);
        end
    end

    always_ff @(posedge clk_sys) begin
        sync1_q  <= joy_data;
        sync2_q  <= sync1_q;
        shadow_q <= shadow_d;
    end

    assign joy_clk  = joy_clk_q;
    assign joy_load = joy_load_q;
    assign joystick = joy_q;
    assign valid    = valid_q;
    assign combo    = combo_q;

endmodule
